ctrled_interval_timer: RTL and testbench
========================================

# ctrled_interval_timer

Multi-channel, parametrised interval timer for the UART communication path. It replaces single-channel, fixed-period start/finish counters with per-channel runtime-loadable periods, one-shot or periodic (auto-reload) mode, explicit stop/abort, and busy status. Typical uses are baud-interval, frame-gap and inter-message delay timing. Each channel produces a one-cycle `tick` pulse on expiry.

## Interface
- `WIDTH`, 25: counter and period width in bits.
- `CHANNELS`, 2: number of independent timer channels (1 to 8).
- `DEFAULT_PERIOD`, 10000000: reset value of every period register. Must fit in `WIDTH` bits and be at least 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  CHANNELS  per-channel start/restart request, sampled each cycle.
- `stop`  in  CHANNELS  per-channel abort request.
- `periodic`  in  CHANNELS  mode, sampled with `start`: 1 = auto-reload, 0 = one-shot.
- `period_we`  in  CHANNELS  per-channel write enable for the period shadow register.
- `period_in`  in  CHANNELS*WIDTH  new period; channel i uses bits [i*WIDTH +: WIDTH].
- `busy`  out  CHANNELS  channel i is running.
- `tick`  out  CHANNELS  one-cycle expiry pulse, registered.
- `count`  out  CHANNELS*WIDTH  current count of each channel, same slicing as `period_in`.

## Operation
- Channels are fully independent. Per channel there is a shadow period register `per_sh`, an active period `per_act`, a latched mode bit, a counter, and a 2-state FSM: IDLE, RUN.
- Reset: FSM = IDLE, `per_sh` = `per_act` = DEFAULT_PERIOD, mode = 0, `count` = 0, `busy` = 0, `tick` = 0.
- `period_we[i]` writes `per_sh` in any state. The write never disturbs a running interval.
- Period value 0 is treated as 1, i.e. a tick every cycle while running.
- Each cycle, evaluate in this priority order:
  1. `stop`: go to IDLE, `count` <= 0, `tick` <= 0. Stop wins over a same-cycle `start` or expiry.
  2. `start`, from IDLE or RUN:
     - `per_act` <= `per_sh`.
     - If `period_we` is set in the same cycle, `period_in` is used instead (write-through).
     - Latch mode from `periodic`.
     - `count` <= 0, go to RUN, `tick` <= 0. A start during RUN restarts the interval, and any same-cycle expiry is discarded.
  3. RUN and `count` == `per_act` − 1 (expiry): `tick` <= 1.
     - Periodic: `count` <= 0, `per_act` <= `per_sh` (new period takes effect at wrap), stay in RUN.
     - One-shot: `count` <= 0, go to IDLE.
  4. RUN otherwise: `count` <= `count` + 1.
  5. IDLE otherwise: hold; `tick` <= 0.
- Count arithmetic is unsigned WIDTH bits. The counter never exceeds `per_act` − 1, so it never wraps.
- `busy` = (FSM == RUN), registered. It is not a decode of `count`.

## Timing
- Start accepted at edge E:
  - `busy` = 1 and `count` = 0 after E.
  - `count` = k after edge E+k.
- First `tick` is high for the cycle after edge E+P, where P = effective period. This is exactly P cycles after the start edge.
- Periodic mode: further ticks after edges E+2P, E+3P, …; tick spacing is exactly P cycles with no slip.
- One-shot mode: `busy` falls on the same edge that `tick` rises.
- Period written mid-run: the first wrap after the write uses the old period; the following interval uses the new one.
- Stop at edge S: `busy` = 0, `count` = 0, and `tick` = 0 after S, even if S is the expiry edge.
- Asynchronous `rst` mid-run: all outputs return to reset values immediately. No tick is produced until a new `start`.

## Test plan
- Reset values: after `rst`, all `busy`/`tick`/`count` are 0. A one-shot start on ch0 with no period write gives a tick exactly 10000000 cycles later (run with a small DEFAULT_PERIOD override, e.g. 20).
- One-shot, P=5 on ch0: start at edge 0 -> `count` 0,1,2,3,4; `tick` high only after edge 5; `busy` 1 during edges 0–4 and 0 after edge 5.
- Periodic, P=3 on ch1 with ch0 idle: ticks after edges 3, 6, 9, …. Write P=5 after edge 4 -> next tick after edge 6, then after edges 11 and 16. Ch0 outputs stay 0 throughout.
- Period 0 in periodic mode: `tick` high every cycle after the start edge; `count` stays 0.
- Simultaneous events, P=4 (expiry at edge E+4):
  - `stop` at E+4 -> no tick, `busy` = 0.
  - `start` at E+4 instead -> no tick, next tick after E+8.
  - `start` and `stop` together -> IDLE.
- `rst` asserted mid-count at `count` = 2 (P=6): outputs clear asynchronously; no tick is produced afterwards; a new start gives a tick 6 cycles later.

Source files
------------

// File: rtl/ctrled_interval_timer.sv
// Multi-channel interval timer with runtime-loadable periods.
// Each channel has a period shadow register, an active period, a latched
// mode bit (one-shot / periodic), an up-counter and a two-state IDLE/RUN FSM.
// A channel emits a registered one-cycle tick when its interval expires.
// Each channel's FSM state is the named signal g_ch[i].state_q, so checkers
// can bind to it directly.
//
// Control protocol: start/stop/period_we are level-sampled request strobes.
// There is no ready; every request is taken on the edge where it is high.
// Per-cycle priority is:
//   stop, then start, then expiry, then counting/hold.
// A start with period_we in the same cycle loads period_in straight into
// the active period.
module ctrled_interval_timer #(
  parameter int WIDTH          = 25,
  parameter int CHANNELS       = 2,
  parameter int DEFAULT_PERIOD = 10000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       period_we,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS*WIDTH-1:0] count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] DEF_PER = WIDTH'(DEFAULT_PERIOD);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] per_sh;
    logic [WIDTH-1:0] per_act;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] pin;
    logic             mode;
    logic             tick_q;
    logic             expire;

    assign pin = period_in[i*WIDTH +: WIDTH];

    // A period of 0 behaves like 1, so the terminal count is 0 in both cases.
    assign last   = (per_act == '0) ? '0 : per_act - WIDTH'(1);
    assign expire = (state_q == RUN) && (cnt == last);

    // Next-state logic for the channel FSM.
    always_comb begin
      state_d = state_q;
      if (stop[i]) begin
        state_d = IDLE;
      end else if (start[i]) begin
        state_d = RUN;
      end else if (expire && !mode) begin
        state_d = IDLE;
      end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Shadow period register; writable at any time without touching the
    // interval currently running.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        per_sh <= DEF_PER;
      end else if (period_we[i]) begin
        per_sh <= pin;
      end
    end

    // Counter, active period, mode latch and tick register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        per_act <= DEF_PER;
        mode    <= 1'b0;
        cnt     <= '0;
        tick_q  <= 1'b0;
      end else if (stop[i]) begin
        cnt    <= '0;
        tick_q <= 1'b0;
      end else if (start[i]) begin
        per_act <= period_we[i] ? pin : per_sh;
        mode    <= periodic[i];
        cnt     <= '0;
        tick_q  <= 1'b0;
      end else if (expire) begin
        // Periodic channels pick up a new period only at the wrap.
        tick_q <= 1'b1;
        cnt    <= '0;
        if (mode) begin
          per_act <= per_sh;
        end
      end else if (state_q == RUN) begin
        cnt    <= cnt + WIDTH'(1);
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign busy[i]                 = (state_q == RUN);
    assign tick[i]                 = tick_q;
    assign count[i*WIDTH +: WIDTH] = cnt;
  end

endmodule

// File: tb/tb_ctrled_interval_timer.sv
// Bench for ctrled_interval_timer: two 8-bit channels, default period 20.
module tb_ctrled_interval_timer;

  localparam int W  = 8;
  localparam int CH = 2;
  localparam int OW = 2 * CH + CH * W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   start = '0;
  logic [CH-1:0]   stop = '0;
  logic [CH-1:0]   periodic = '0;
  logic [CH-1:0]   period_we = '0;
  logic [CH*W-1:0] period_in = '0;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   tick;
  logic [CH*W-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  ctrled_interval_timer #(
    .WIDTH(W),
    .CHANNELS(CH),
    .DEFAULT_PERIOD(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .periodic(periodic),
    .period_we(period_we),
    .period_in(period_in),
    .busy(busy),
    .tick(tick),
    .count(count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] observed();
    return {busy, tick, count};
  endfunction

  // Spec-level expectation for a channel k cycles after its start edge:
  // returns {busy, tick, count}.
  function automatic logic [W+1:0] exp_at(input int p, input logic per, input int k);
    int eff;
    int c;
    eff = (p == 0) ? 1 : p;
    if (per) begin
      c = k % eff;
      return {1'b1, (k > 0 && c == 0), W'(c)};
    end
    if (k < eff) return {1'b1, 1'b0, W'(k)};
    if (k == eff) return {1'b0, 1'b1, W'(0)};
    return '0;
  endfunction

  // Places one channel's {busy,tick,count} into the full output vector,
  // the other channel expected idle (all zero).
  function automatic logic [OW-1:0] one(input int ch, input logic [W+1:0] v);
    logic [OW-1:0] r;
    r = '0;
    r[2*CH*W/W*0 + CH*W + CH + ch] = v[W+1];
    r[CH*W + ch]                   = v[W];
    r[ch*W +: W]                   = v[W-1:0];
    return r;
  endfunction

  // One clock: push expectation, let the edge happen, pop and compare.
  task automatic cycle(input logic [OW-1:0] exp, input string tag);
    logic [OW-1:0] e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, observed(), e);
  endtask

  task automatic start_ch(input int ch, input logic per, input logic we, input logic [W-1:0] p, input string tag);
    start[ch]          = 1'b1;
    periodic[ch]       = per;
    period_we[ch]      = we;
    period_in[ch*W +: W] = p;
    cycle(one(ch, {1'b1, 1'b0, W'(0)}), tag);
    start     = '0;
    period_we = '0;
  endtask

  task automatic run(input int ch, input int p, input logic per, input int k0, input int k1, input string tag);
    for (int k = k0; k <= k1; k++) begin
      cycle(one(ch, exp_at(p, per, k)), $sformatf("%s_k%0d", tag, k));
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle('0, $sformatf("%s_%0d", tag, k));
  endtask

  initial begin
    // Reset values.
    #12;
    check_eq("reset_outputs", observed(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // One-shot with the default period of 20, no period write.
    start_ch(0, 1'b0, 1'b0, 8'd0, "def_start");
    run(0, 20, 1'b0, 1, 22, "def");

    // One-shot P=5 on ch0.
    start_ch(0, 1'b0, 1'b1, 8'd5, "os5_start");
    run(0, 5, 1'b0, 1, 8, "os5");

    // Periodic P=3 on ch1, P=5 written in the cycle after edge 4.
    start_ch(1, 1'b1, 1'b1, 8'd3, "per3_start");
    run(1, 3, 1'b1, 1, 4, "per3");
    period_we[1]   = 1'b1;
    period_in[W +: W] = 8'd5;
    cycle(one(1, exp_at(3, 1'b1, 5)), "per3_k5_wr");
    period_we = '0;
    cycle(one(1, exp_at(3, 1'b1, 6)), "per3_k6_oldwrap");
    for (int k = 7; k <= 17; k++) begin
      cycle(one(1, exp_at(5, 1'b1, k - 6)), $sformatf("per5_k%0d", k));
    end
    stop[1] = 1'b1;
    cycle('0, "per_stop");
    stop = '0;

    // Period 0 periodic: tick every cycle, count stays 0.
    start_ch(1, 1'b1, 1'b1, 8'd0, "p0_start");
    run(1, 0, 1'b1, 1, 5, "p0");
    stop[1] = 1'b1;
    cycle('0, "p0_stop");
    stop = '0;

    // Stop on the expiry edge, P=4.
    start_ch(0, 1'b1, 1'b1, 8'd4, "sx_start");
    run(0, 4, 1'b1, 1, 3, "sx");
    stop[0] = 1'b1;
    cycle('0, "sx_stop_at_expiry");
    stop = '0;
    idle(2, "sx_idle");

    // Restart on the expiry edge: no tick, next tick 4 cycles later.
    start_ch(0, 1'b1, 1'b1, 8'd4, "rx_start");
    run(0, 4, 1'b1, 1, 3, "rx");
    start_ch(0, 1'b1, 1'b0, 8'd0, "rx_restart_at_expiry");
    run(0, 4, 1'b1, 1, 5, "rx2");

    // Start and stop together while running -> IDLE.
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    cycle('0, "startstop");
    start = '0;
    stop  = '0;
    idle(2, "ss_idle");

    // Asynchronous reset mid-count (count 2, P=6).
    start_ch(0, 1'b0, 1'b1, 8'd6, "ar_start");
    run(0, 6, 1'b0, 1, 2, "ar");
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_clear", observed(), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_released", observed(), '0);
    idle(10, "ar_no_tick");
    start_ch(0, 1'b0, 1'b1, 8'd6, "ar2_start");
    run(0, 6, 1'b0, 1, 8, "ar2");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
